// File: rtl/uart_tx_cfg_if.sv
// Write-side bus of the buffered UART transmitter.
//   P_DATA     : word to transmit
//   Data_Valid : write strobe, one word per accepted cycle
//   fifo_full  : buffer holds FIFO_DEPTH words, writes are refused
//   overrun    : one-cycle pulse after a write was refused
// master = producer of words, slave = the transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  fifo_full;
  logic                  overrun;

  modport master (output P_DATA, Data_Valid, input fifo_full, overrun);
  modport slave  (input P_DATA, Data_Valid, output fifo_full, overrun);
endinterface

// File: rtl/uart_tx_cfg.sv
// Buffered, parametrised UART transmitter. Words are written into a small
// FIFO and serialised LSB-first: start bit, DATA_WIDTH data bits, optional
// parity, one or two stop bits, PRESCALE clocks per bit.
// Ports:
//   CLK, RST  : clock, asynchronous active-low reset
//   bus       : write bus (P_DATA, Data_Valid in; fifo_full, overrun out)
//   PAR_EN    : insert parity bit after data
//   PAR_TYP   : 0 = even, 1 = odd parity
//   STOP2     : 1 = two stop bits
//   PRESCALE  : clocks per bit (0 and 1 both mean 1)
//   TX_OUT    : serial line, idle high, registered
//   busy      : frame in progress or FIFO non-empty
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_cfg_if.slave       bus,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  input  logic [PRESC_W-1:0] PRESCALE,
  output logic               TX_OUT,
  output logic               busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, nempty, push, pop;
  logic                  overrun_q;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign nempty = (count != '0);
  // fullness is judged on the current count, so a same-cycle pop never
  // makes room for a write
  assign push   = bus.Data_Valid & ~full;

  assign bus.fifo_full = full;
  assign bus.overrun   = overrun_q;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.P_DATA;
  end

  // pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count + CW'(push) - CW'(pop);
      overrun_q <= bus.Data_Valid & full;
    end
  end

  // ---------------- serialiser ----------------
  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit, par_en_lat, stop2_lat, stop_idx;
  logic [PRESC_W-1:0]    p_lat, presc_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  tick, last_stop;

  assign tick      = (presc_cnt == p_lat - PRESC_W'(1));
  assign last_stop = ~stop2_lat | stop_idx;
  // pop when idle, or at the very end of the last stop bit so the next
  // start bit follows with no gap
  assign pop       = nempty & ((state == IDLE) |
                               ((state == STOP) & tick & last_stop));

  assign busy = (state != IDLE) | nempty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_en_lat <= 1'b0;
      stop2_lat  <= 1'b0;
      stop_idx   <= 1'b0;
      p_lat      <= PRESC_W'(1);
      presc_cnt  <= '0;
      bit_cnt    <= '0;
    end else if (pop) begin
      // word and frame configuration are frozen for the whole frame
      shreg      <= mem[rd_ptr];
      par_bit    <= PAR_TYP ? ~^mem[rd_ptr] : ^mem[rd_ptr];
      par_en_lat <= PAR_EN;
      stop2_lat  <= STOP2;
      p_lat      <= (PRESCALE > PRESC_W'(1)) ? PRESCALE : PRESC_W'(1);
      presc_cnt  <= '0;
      bit_cnt    <= '0;
      stop_idx   <= 1'b0;
      state      <= START;
      TX_OUT     <= 1'b0;
    end else if (state != IDLE) begin
      if (!tick) begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end else begin
        presc_cnt <= '0;
        case (state)
          START: begin
            state  <= DATA;
            TX_OUT <= shreg[0];
          end
          DATA: begin
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              stop_idx <= 1'b0;
              if (par_en_lat) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg >> 1;
              TX_OUT  <= shreg[1];
            end
          end
          PARITY: begin
            state    <= STOP;
            stop_idx <= 1'b0;
            TX_OUT   <= 1'b1;
          end
          STOP: begin
            // the non-empty end-of-stop case is taken by the pop branch
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else begin
              state  <= IDLE;
              TX_OUT <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: expected frames are queued on write and
// checked bit-by-bit, clock-by-clock by a line monitor.
module tb_uart_tx_cfg;
  logic       CLK = 1'b0;
  logic       RST;
  logic       PAR_EN, PAR_TYP, STOP2;
  logic [7:0] PRESCALE;
  logic       TX_OUT, busy;

  uart_tx_cfg_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_W(8)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] w;
    bit         par_en, par_typ, stop2;
    int         p;
  } ent_t;

  ent_t sb[$];
  int   starts[$];
  int   n_checks = 0, n_errors = 0;
  int   ovr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- line monitor ----------------
  bit   mon_active = 0;
  ent_t cur;
  bit   ebits [16];
  int   nb, bit_i, cyc_i;

  always @(negedge CLK) begin
    if (!RST) begin
      mon_active = 0;
    end else begin
      if (bus.overrun === 1'b1) ovr_cnt++;
      if (!mon_active && TX_OUT === 1'b0) begin
        chk("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          ebits[0] = 1'b0;
          for (int i = 0; i < 8; i++) ebits[1+i] = cur.w[i];
          nb = 9;
          if (cur.par_en) begin
            ebits[nb] = cur.par_typ ? ~^cur.w : ^cur.w;
            nb++;
          end
          ebits[nb] = 1'b1; nb++;
          if (cur.stop2) begin ebits[nb] = 1'b1; nb++; end
          mon_active = 1; bit_i = 0; cyc_i = 0;
          starts.push_back(cyc);
        end
      end
      if (mon_active) begin
        chk($sformatf("tx_w%0h_bit%0d", cur.w, bit_i), TX_OUT, ebits[bit_i]);
        cyc_i++;
        if (cyc_i == cur.p) begin
          cyc_i = 0;
          bit_i++;
          if (bit_i == nb) mon_active = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input bit pe, input bit pt, input bit s2, input logic [7:0] pr);
    PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = pr;
  endtask

  // presents a word for the next rising edge; queues it if it will be taken
  task automatic wr(input logic [7:0] w, input bit accept);
    ent_t e;
    @(posedge CLK); #1;
    bus.P_DATA = w; bus.Data_Valid = 1'b1;
    if (accept) begin
      e.w = w; e.par_en = PAR_EN; e.par_typ = PAR_TYP; e.stop2 = STOP2;
      e.p = (PRESCALE == 0) ? 1 : int'(PRESCALE);
      sb.push_back(e);
    end
  endtask

  task automatic dv_off();
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
  endtask

  task automatic wait_start(input int n);
    int k = 0;
    while (starts.size() < n && k < 2000) begin @(negedge CLK); k++; end
    chk("start_timeout", starts.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy !== 1'b0 || mon_active) && k < 3000) begin @(negedge CLK); k++; end
    chk("idle_timeout", busy === 1'b0 && !mon_active, 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // single frame: checks latency-free length via busy around the frame end
  task automatic one_frame(input logic [7:0] w, input int len, input string tag);
    int s;
    starts.delete();
    wr(w, 1);
    dv_off();
    wait_start(1);
    s = (starts.size() > 0) ? starts[0] : cyc;
    wait_cyc(s + len - 1);
    chk({tag, "_busy_last"}, busy, 1);
    wait_cyc(s + len);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_tx_end"}, TX_OUT, 1);
    wait_idle();
  endtask

  int e0, s, bad;

  initial begin
    RST = 1'b0;
    bus.P_DATA = '0; bus.Data_Valid = 1'b0;
    set_cfg(0, 0, 0, 8'd1);
    repeat (3) @(negedge CLK);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", bus.fifo_full, 0);
    chk("rst_overrun", bus.overrun, 0);
    #2 RST = 1'b1;

    // 0xA5, P=4, even parity, one stop: 44 clocks, start one clock after write
    set_cfg(1, 0, 0, 8'd4);
    starts.delete();
    wr(8'hA5, 1);
    @(posedge CLK); #1;
    e0 = cyc;
    bus.Data_Valid = 1'b0;
    @(negedge CLK);
    chk("busy_after_write", busy, 1);
    chk("tx_before_start", TX_OUT, 1);
    wait_start(1);
    chk("start_latency", starts[0], e0 + 1);
    wait_cyc(starts[0] + 43);
    chk("a5_busy_last", busy, 1);
    wait_cyc(starts[0] + 44);
    chk("a5_busy_end", busy, 0);
    wait_idle();

    // odd parity of 0x00 is 1; no parity + two stops is also 11 clocks
    set_cfg(1, 1, 0, 8'd1);
    one_frame(8'h00, 11, "odd_par");
    set_cfg(0, 0, 1, 8'd1);
    one_frame(8'h00, 11, "stop2");
    // PRESCALE=0 acts as 1
    set_cfg(1, 0, 0, 8'd0);
    one_frame(8'h3C, 11, "presc0");

    // overflow: the first word is popped on the following edge, so it takes
    // six consecutive writes to hit a refused one
    set_cfg(0, 0, 0, 8'd2);
    starts.delete();
    ovr_cnt = 0;
    wr(8'h11, 1); wr(8'h22, 1); wr(8'h33, 1); wr(8'h44, 1); wr(8'h55, 1);
    wr(8'h66, 0);
    chk("fifo_full_set", bus.fifo_full, 1);
    chk("overrun_early", bus.overrun, 0);
    dv_off();
    chk("overrun_pulse", bus.overrun, 1);
    @(posedge CLK); #1;
    chk("overrun_clear", bus.overrun, 0);
    chk("fifo_full_hold", bus.fifo_full, 1);
    wait_start(5);
    for (int i = 0; i < 4 && i + 1 < starts.size(); i++)
      chk($sformatf("b2b_gap%0d", i), starts[i+1] - starts[i], 20);
    wait_idle();
    chk("overrun_once", ovr_cnt, 1);
    chk("fifo_full_drained", bus.fifo_full, 0);

    // config change mid-frame applies to the next frame only
    set_cfg(0, 0, 0, 8'd4);
    starts.delete();
    wr(8'h5A, 1);
    dv_off();
    wait_start(1);
    wait_cyc(starts[0] + 10);
    set_cfg(0, 0, 1, 8'd8);
    wr(8'hC3, 1);
    dv_off();
    wait_start(2);
    chk("cfg_first_len", starts[1] - starts[0], 40);
    wait_cyc(starts[1] + 87);
    chk("cfg_second_busy_last", busy, 1);
    wait_cyc(starts[1] + 88);
    chk("cfg_second_busy_end", busy, 0);
    wait_idle();

    // reset during data bit 3 with two words queued
    set_cfg(0, 0, 0, 8'd4);
    starts.delete();
    wr(8'h01, 1); wr(8'h02, 1); wr(8'h03, 1);
    dv_off();
    wait_start(1);
    wait_cyc(starts[0] + 17);
    #2 RST = 1'b0;
    #1;
    chk("arst_tx", TX_OUT, 1);
    chk("arst_busy", busy, 0);
    chk("arst_full", bus.fifo_full, 0);
    sb.delete();
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    starts.delete();
    bad = 0;
    repeat (30) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("quiet_after_reset", bad, 0);
    chk("no_frames_after_reset", starts.size(), 0);
    one_frame(8'h81, 40, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
